// File: rtl/regfile_sequencer.sv
// Purpose: steps one instruction at a time through a single-port 4x4 register file and an external
//          combinational ULA (read ra, read rb, execute, write rd); also load-immediate and readback.
// Latency: accept->done is ALU 6, READ 3, LOAD 2, reserved 1 cycles; backpressure: instr_ready only in IDLE.
// Ports:   instr_* (instruction source, valid/ready), rf_* (register file), alu_* (ULA), done/err/result.
// Config:  define SEQ_STATS_EN to add the saturating retired_count[7:0] output.
module regfile_sequencer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_cmd,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_ra,
    input  logic [ADDR_W-1:0] instr_rb,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
`ifdef SEQ_STATS_EN
    ,
    output logic [7:0]        retired_count
`endif
);

    localparam logic [1:0] CMD_ALU  = 2'b00;
    localparam logic [1:0] CMD_LOAD = 2'b01;
    localparam logic [1:0] CMD_READ = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        EXEC,
        WB
    } state_t;

    state_t            state;

    // Instruction fields captured at accept; the source is free to change them afterwards.
    logic [1:0]        cmd_q;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W-1:0] rb_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] wb_val;

    assign wb_val = (cmd_q == CMD_LOAD) ? imm_q : res_q;

    // Register-file controls are a pure decode of the state so the write can
    // only ever happen in WB, after both operand reads have completed.
    always_comb begin
        instr_ready = (state == IDLE);
        rf_we       = (state == WB);
        rf_addr     = '0;
        rf_data_in  = '0;
        case (state)
            RD_A:          rf_addr = ra_q;
            RD_B, CAP_B:   rf_addr = rb_q;
            WB: begin
                rf_addr    = rd_q;
                rf_data_in = wb_val;
            end
            default:       rf_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cmd_q  <= '0;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            imm_q  <= '0;
            opa_q  <= '0;
            res_q  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        cmd_q <= instr_cmd;
                        op_q  <= instr_op;
                        ra_q  <= instr_ra;
                        rb_q  <= instr_rb;
                        rd_q  <= instr_rd;
                        imm_q <= instr_imm;
                        case (instr_cmd)
                            CMD_ALU, CMD_READ: state <= RD_A;
                            CMD_LOAD:          state <= WB;
                            default: begin
                                // Reserved command retires immediately, no register access.
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_A: state <= RD_B;
                RD_B: begin
                    // Read data returned here belongs to the ra address presented in RD_A.
                    opa_q <= rf_data_out;
                    if (cmd_q == CMD_READ) begin
                        result <= rf_data_out;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state <= CAP_B;
                    end
                end
                CAP_B: begin
                    alu_b  <= rf_data_out;
                    alu_a  <= opa_q;
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    res_q <= alu_result;
                    state <= WB;
                end
                WB: begin
                    result <= wb_val;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_count <= 8'd0;
        end else if (done && (retired_count != 8'hFF)) begin
            retired_count <= retired_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Purpose: randomized and directed check of regfile_sequencer against an architectural register model.
// Latency: per-instruction latency, write-back, operands and result checked at every retirement.
// Backpressure: instructions wait on instr_ready; valid is held across busy cycles for back-to-back issue.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_cmd = '0;
    logic [2:0] instr_op = '0;
    logic [1:0] instr_ra = '0;
    logic [1:0] instr_rb = '0;
    logic [1:0] instr_rd = '0;
    logic [3:0] instr_imm = '0;
    logic [1:0] rf_addr;
    logic       rf_we;
    logic [3:0] rf_data_in;
    logic [3:0] rf_data_out;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       done;
    logic       err;
    logic [3:0] result;
`ifdef SEQ_STATS_EN
    logic [7:0] retired_count;
`endif

    regfile_sequencer #(.DATA_W(4), .ADDR_W(2), .OP_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_cmd   (instr_cmd),
        .instr_op    (instr_op),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_rd    (instr_rd),
        .instr_imm   (instr_imm),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .err         (err),
        .result      (result)
`ifdef SEQ_STATS_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ULA: small opcode table, combinational.
    function automatic logic [3:0] ula(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    ula = a + b;
            3'd1:    ula = a - b;
            3'd2:    ula = a & b;
            3'd3:    ula = a | b;
            3'd4:    ula = a ^ b;
            3'd5:    ula = ~a;
            3'd6:    ula = a;
            default: ula = b;
        endcase
    endfunction

    assign alu_result = ula(alu_op, alu_a, alu_b);

    // Register file: write when we=1, otherwise registered read of rf_addr.
    logic [3:0] rf_mem [4];
    logic [3:0] rf_rd;
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] <= rf_data_in;
        else       rf_rd <= rf_mem[rf_addr];
    end
    assign rf_data_out = rf_rd;

    // Architectural reference state.
    logic [3:0] ref_regs [4];
    logic [3:0] model_result = '0;
    int n_checks = 0;
    int n_fail = 0;
    int last_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a negedge. Leaves time just after the done negedge.
    task automatic run_instr(input logic [1:0] cmd, input logic [2:0] op, input logic [1:0] ra,
                             input logic [1:0] rb, input logic [1:0] rd, input logic [3:0] imm,
                             input bit keep);
        int n, acc, we_n, lat;
        logic [3:0] exp, ea, eb;
        instr_cmd = cmd; instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(instr_ready), 32'd1);
        // Architectural effect of this instruction.
        ea = ref_regs[ra];
        eb = ref_regs[rb];
        case (cmd)
            2'd0:    exp = ula(op, ea, eb);
            2'd1:    exp = imm;
            2'd2:    exp = ea;
            default: exp = model_result;
        endcase
        if (cmd == 2'd0 || cmd == 2'd1) ref_regs[rd] = exp;
        model_result = exp;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (cmd == 2'd3) instr_valid = 1'b0;
        we_n = 0;
        for (int k = 0; k < 12; k++) begin
            if (rf_we) begin
                we_n++;
                check("we_allowed", 32'(cmd < 2'd2), 32'd1);
                check("we_addr", 32'(rf_addr), 32'(rd));
                check("we_data", 32'(rf_data_in), 32'(exp));
            end
            if (done) break;
            if (err) check("err_without_done", 32'(err), 32'd0);
            @(negedge clk);
        end
        lat = cyc - acc + 1;
        check("done_seen", 32'(done), 32'd1);
        case (cmd)
            2'd0:    check("lat_alu", 32'(lat), 32'd6);
            2'd1:    check("lat_load", 32'(lat), 32'd2);
            2'd2:    check("lat_read", 32'(lat), 32'd3);
            default: check("lat_rsvd", 32'(lat), 32'd1);
        endcase
        check("err", 32'(err), 32'(cmd == 2'd3));
        check("result", 32'(result), 32'(exp));
        check("we_cycles", 32'(we_n), 32'(cmd < 2'd2));
        if (cmd == 2'd0) begin
            check("alu_a", 32'(alu_a), 32'(ea));
            check("alu_b", 32'(alu_b), 32'(eb));
            check("alu_op", 32'(alu_op), 32'(op));
        end
        last_done = cyc;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        model_result = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        #1;
        check("reset_ready", 32'(instr_ready), 32'd1);
        check("reset_outs", {20'd0, rf_we, rf_addr, rf_data_in, done, err, result}, 32'd0);
        check("reset_alu", {21'd0, alu_a, alu_b, alu_op}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Put the register file into a known state.
        for (int i = 0; i < 4; i++) run_instr(2'd1, 3'd0, 2'd0, 2'd0, 2'(i), 4'(i + 7), 1'b0);

        // Directed sequence.
        run_instr(2'd1, 3'd0, 2'd0, 2'd0, 2'd2, 4'hA, 1'b0);
        run_instr(2'd1, 3'd0, 2'd0, 2'd0, 2'd0, 4'h3, 1'b0);
        run_instr(2'd1, 3'd0, 2'd0, 2'd0, 2'd1, 4'h5, 1'b0);
        run_instr(2'd0, 3'd0, 2'd0, 2'd1, 2'd3, 4'h0, 1'b0);
        check("add_r3", 32'(rf_mem[3]), 32'h8);
        run_instr(2'd2, 3'd0, 2'd3, 2'd0, 2'd0, 4'h0, 1'b0);
        check("read_r3", 32'(result), 32'h8);

        // Back-to-back ALU with valid held high; ra==rb and rd==ra included.
        run_instr(2'd0, 3'd0, 2'd3, 2'd3, 2'd3, 4'h0, 1'b1);
        d0 = last_done;
        run_instr(2'd0, 3'd1, 2'd3, 2'd2, 2'd2, 4'h0, 1'b1);
        check("b2b_gap1", 32'(last_done - d0), 32'd6);
        d0 = last_done;
        run_instr(2'd0, 3'd4, 2'd0, 2'd1, 2'd1, 4'h0, 1'b0);
        check("b2b_gap2", 32'(last_done - d0), 32'd6);

        // Reserved command.
        run_instr(2'd3, 3'd0, 2'd1, 2'd2, 2'd3, 4'hF, 1'b0);

        // Reset while in EXEC: no write, no done, rd untouched.
        instr_cmd = 2'd0; instr_op = 3'd5; instr_ra = 2'd0; instr_rb = 2'd1; instr_rd = 2'd2;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(instr_ready), 32'd1);
        check("abort_we", 32'(rf_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        model_result = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || rf_we) check("abort_quiet", {30'd0, done, rf_we}, 32'd0);
        end
        check("abort_rd", 32'(rf_mem[2]), 32'(ref_regs[2]));

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] c;
            bit keep;
            r = $urandom_range(0, 9);
            c = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            keep = 1'($urandom_range(0, 1));
            run_instr(c, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) check("final_reg", 32'(rf_mem[i]), 32'(ref_regs[i]));

`ifdef SEQ_STATS_EN
        pulse_reset();
        @(negedge clk);
        check("stats_reset", 32'(retired_count), 32'd0);
        for (int i = 0; i < 260; i++) begin
            run_instr(2'd1, 3'd0, 2'd0, 2'd0, 2'(i), 4'(i), 1'b1);
            if (i == 9) begin
                @(negedge clk);
                check("stats_ten", 32'(retired_count), 32'd10);
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        check("stats_sat", 32'(retired_count), 32'd255);
        pulse_reset();
        #1;
        check("stats_clear", 32'(retired_count), 32'd0);
`else
        pulse_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
